// File: rtl/vc_elastic_buffer.sv
// Multi-virtual-channel elastic input buffer.
// One upstream flit port, tagged with a VC number, fills NUM_VC independent
// circular FIFOs. A round-robin stage presents one flit downstream with
// first-word-fall-through. The arbitration locks while the output is stalled.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   valid_in/vc_in/data_in  upstream flit, VC tag and valid
//   ready_out[NUM_VC]   per-VC "not full" to upstream (registered state only)
//   valid_out/vc_out/data_out  presented downstream flit (data 0 when idle)
//   ready_in            downstream accepts the presented flit
module vc_elastic_buffer #(
  parameter int unsigned FLIT_SIZE = 16,
  parameter int unsigned NUM_VC    = 4,
  parameter int unsigned VC_W      = 2,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PTR_W     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic [VC_W-1:0]      vc_in,
  input  logic [FLIT_SIZE-1:0] data_in,
  output logic [NUM_VC-1:0]    ready_out,
  output logic                 valid_out,
  output logic [VC_W-1:0]      vc_out,
  output logic [FLIT_SIZE-1:0] data_out,
  input  logic                 ready_in
);

  // Storage and pointers; pointer MSB is the wrap bit.
  logic [FLIT_SIZE-1:0] mem_q  [NUM_VC][DEPTH];
  logic [PTR_W:0]       head_q [NUM_VC];
  logic [PTR_W:0]       head_d [NUM_VC];
  logic [PTR_W:0]       tail_q [NUM_VC];
  logic [PTR_W:0]       tail_d [NUM_VC];
  logic [VC_W-1:0]      rr_q, rr_d;
  logic                 lock_q, lock_d;
  logic [VC_W-1:0]      lock_vc_q, lock_vc_d;

  logic [NUM_VC-1:0]    empty_c;
  logic [NUM_VC-1:0]    full_c;
  logic [NUM_VC-1:0]    push_c;
  logic                 any_c;
  logic                 pop_c;
  logic [VC_W-1:0]      cand_c;
  logic [VC_W-1:0]      sel_c;
  logic [PTR_W-1:0]     rd_ptr_c;
  int                   best_c;
  int                   dist_c;

  // Per-VC occupancy status.
  always_comb begin
    empty_c = '0;
    full_c  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      empty_c[v] = (head_q[v] == tail_q[v]);
      full_c[v]  = (head_q[v][PTR_W-1:0] == tail_q[v][PTR_W-1:0]) &&
                   (head_q[v][PTR_W] != tail_q[v][PTR_W]);
    end
  end

  assign any_c     = |(~empty_c);
  assign ready_out = ~full_c & {NUM_VC{~reset}};

  // Round-robin search: pick the non-empty VC closest to rr in rotated order.
  always_comb begin
    cand_c = '0;
    best_c = int'(NUM_VC);
    dist_c = 0;
    for (int v = 0; v < NUM_VC; v++) begin
      dist_c = v - int'(rr_q);
      if (dist_c < 0) dist_c = dist_c + int'(NUM_VC);
      if (!empty_c[v] && (dist_c < best_c)) begin
        best_c = dist_c;
        cand_c = VC_W'(v);
      end
    end
  end

  // A stalled flit keeps the output pinned to its VC.
  assign sel_c     = lock_q ? lock_vc_q : cand_c;
  assign valid_out = (lock_q | any_c) & ~reset;
  assign vc_out    = valid_out ? sel_c : '0;
  assign rd_ptr_c  = tail_q[sel_c][PTR_W-1:0];
  assign data_out  = valid_out ? mem_q[sel_c][rd_ptr_c] : '0;
  assign pop_c     = valid_out & ready_in;

  // Accept only in-range tags into a non-full VC; fullness uses pre-pop state.
  always_comb begin
    push_c = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      push_c[v] = valid_in & ~reset & (vc_in == VC_W'(v)) & ~full_c[v];
    end
  end

  // Next-state for pointers, round-robin and lock.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    rr_d      = rr_q;
    lock_d    = lock_q;
    lock_vc_d = lock_vc_q;
    for (int v = 0; v < NUM_VC; v++) begin
      if (push_c[v]) head_d[v] = head_q[v] + (PTR_W+1)'(1);
    end
    if (pop_c) begin
      tail_d[sel_c] = tail_q[sel_c] + (PTR_W+1)'(1);
      rr_d = (32'(sel_c) == NUM_VC - 1) ? '0 : sel_c + VC_W'(1);
    end
    if (valid_out && !ready_in) begin
      lock_d    = 1'b1;
      lock_vc_d = sel_c;
    end else if (pop_c) begin
      lock_d = 1'b0;
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        head_q[v] <= '0;
        tail_q[v] <= '0;
      end
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_vc_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_vc_q <= lock_vc_d;
    end
  end

  // Flit storage; contents survive reset but become unreachable.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (push_c[v]) mem_q[v][head_q[v][PTR_W-1:0]] <= data_in;
    end
  end

endmodule
